// File: rtl/board_io_conditioner.sv
// Board-level I/O front end: sequences the core reset from the clock wizard lock
// and synchronises, debounces and edge-detects a vector of raw board inputs.
`timescale 1ns/1ps
module board_io_conditioner #(
    parameter int              WIDTH           = 8,
    parameter int              SYNC_STAGES     = 2,
    parameter int              DEBOUNCE_CYCLES = 1000,
    parameter int              RST_HOLD        = 16,
    parameter logic [WIDTH-1:0] INIT           = '0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             pll_locked,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] clean_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic             core_reset,
    output logic             ready,
    output logic [1:0]       seq_state
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        COUNT = 2'd1,
        RUN   = 2'd2
    } seq_t;

    logic [SYNC_STAGES-1:0] lock_sync;
    logic [WIDTH-1:0]       raw_sync [SYNC_STAGES];
    logic                   locked_s;
    logic [WIDTH-1:0]       raw_s;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lock_sync <= '0;
            for (int s = 0; s < SYNC_STAGES; s++) begin
                raw_sync[s] <= '0;
            end
        end else begin
            lock_sync   <= {lock_sync[SYNC_STAGES-2:0], pll_locked};
            raw_sync[0] <= raw_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                raw_sync[s] <= raw_sync[s-1];
            end
        end
    end

    assign locked_s = lock_sync[SYNC_STAGES-1];
    assign raw_s    = raw_sync[SYNC_STAGES-1];

    // Per-bit debounce: a differing level must persist DEBOUNCE_CYCLES cycles
    // in a row; any return to the accepted level restarts the count.
    logic [CW-1:0]    db_cnt [WIDTH];
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] fall_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            clean_out <= INIT;
            rise_q    <= '0;
            fall_q    <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            rise_q <= '0;
            fall_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                if (raw_s[i] == clean_out[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    clean_out[i] <= raw_s[i];
                    db_cnt[i]    <= '0;
                    rise_q[i]    <= raw_s[i];
                    fall_q[i]    <= ~raw_s[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + CW'(1);
                end
            end
        end
    end

    // The level keeps tracking during a core reset; only the pulses are masked.
    assign rise_pulse = rise_q & {WIDTH{~core_reset}};
    assign fall_pulse = fall_q & {WIDTH{~core_reset}};

    seq_t          state;
    logic [HW-1:0] hold_cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= HOLD;
            hold_cnt   <= '0;
            core_reset <= 1'b1;
            ready      <= 1'b0;
        end else begin
            case (state)
                HOLD: begin
                    hold_cnt   <= '0;
                    core_reset <= 1'b1;
                    ready      <= 1'b0;
                    if (locked_s) state <= COUNT;
                end
                COUNT: begin
                    if (!locked_s) begin
                        state    <= HOLD;
                        hold_cnt <= '0;
                    end else if (hold_cnt == HW'(RST_HOLD - 1)) begin
                        state      <= RUN;
                        core_reset <= 1'b0;
                        ready      <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                RUN: begin
                    if (!locked_s) begin
                        state      <= HOLD;
                        hold_cnt   <= '0;
                        core_reset <= 1'b1;
                        ready      <= 1'b0;
                    end
                end
                default: begin
                    state      <= HOLD;
                    hold_cnt   <= '0;
                    core_reset <= 1'b1;
                    ready      <= 1'b0;
                end
            endcase
        end
    end

    assign seq_state = state;

endmodule
